// File: rtl/cpu_csr_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_csr_axi_master
//  Purpose  : Bridges a simple CPU CSR command/response port onto a
//             single-beat AXI4 master. One transaction in flight at a time,
//             with alignment check, ID/LAST check and response timeout.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_csr_axi_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        s_aclk,
    input  logic        s_areset,
    // CPU command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_id,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    // CPU response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [3:0]  rsp_id,
    output logic [2:0]  rsp_err,
    // AXI write address
    output logic [3:0]  m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    // AXI write data
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    // AXI write response
    input  logic [3:0]  m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    // AXI read address
    output logic [3:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    // AXI read data
    input  logic [3:0]  m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR      = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_ADDR = 3'd3;
    localparam logic [2:0] c_RD_DATA = 3'd4;
    localparam logic [2:0] c_RSP     = 3'd5;
    localparam logic [2:0] c_DRAIN   = 3'd6;

    // Counter only needs to span 0 .. TIMEOUT_CYCLES-1; the terminal value
    // is checked before the increment that would reach TIMEOUT_CYCLES.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]         r_state;
    logic               r_write;
    logic [3:0]         r_id;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_timed_out;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rsp_rdata;
    logic [1:0]         r_rsp_resp;
    logic [2:0]         r_rsp_err;

    logic w_cmd_fire;
    logic w_aw_done;
    logic w_w_done;
    logic w_timeout;

    assign cmd_ready  = (r_state == c_IDLE) && !s_areset;
    assign w_cmd_fire = cmd_valid && cmd_ready;

    // A channel is finished once its valid is already low or handshakes now.
    assign w_aw_done  = !r_awvalid || m_axi_awready;
    assign w_w_done   = !r_wvalid  || m_axi_wready;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

    // Fixed single-beat, 4-byte, INCR attributes on both address channels.
    assign m_axi_awid    = r_id;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_arid    = r_id;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (r_state == c_RD_ADDR);
    // DRAIN keeps the ready of whichever channel timed out, to swallow the late beat.
    assign m_axi_bready  = (r_state == c_WR_RESP) || ((r_state == c_DRAIN) &&  r_write);
    assign m_axi_rready  = (r_state == c_RD_DATA) || ((r_state == c_DRAIN) && !r_write);

    assign rsp_valid = (r_state == c_RSP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign rsp_id    = r_id;
    assign rsp_err   = r_rsp_err;

    // Transaction sequencer: command capture, AXI handshakes, response and timeout.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            r_state     <= c_IDLE;
            r_write     <= 1'b0;
            r_id        <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_timed_out <= 1'b0;
            r_cnt       <= '0;
            r_rsp_rdata <= 32'd0;
            r_rsp_resp  <= 2'b00;
            r_rsp_err   <= 3'b000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_cmd_fire) begin
                        r_write     <= cmd_write;
                        r_id        <= cmd_id;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_timed_out <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_resp  <= 2'b00;
                        r_rsp_err   <= 3'b000;
                        if (cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer SLVERR locally, never touch the bus.
                            r_rsp_resp <= 2'b10;
                            r_rsp_err  <= 3'b001;
                            r_state    <= c_RSP;
                        end else if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_WR;
                        end else begin
                            r_state <= c_RD_ADDR;
                        end
                    end
                end
                c_WR: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_cnt   <= '0;
                        r_state <= c_WR_RESP;
                    end
                end
                c_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_rsp_resp <= m_axi_bresp;
                        r_rsp_err  <= {1'b0, (m_axi_bid != r_id), 1'b0};
                        r_state    <= c_RSP;
                    end else if (w_timeout) begin
                        r_rsp_resp  <= 2'b11;
                        r_rsp_err   <= 3'b100;
                        r_timed_out <= 1'b1;
                        r_state     <= c_RSP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_cnt   <= '0;
                        r_state <= c_RD_DATA;
                    end
                end
                c_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_err   <= {1'b0, (m_axi_rid != r_id) || !m_axi_rlast, 1'b0};
                        r_state     <= c_RSP;
                    end else if (w_timeout) begin
                        r_rsp_resp  <= 2'b11;
                        r_rsp_err   <= 3'b100;
                        r_timed_out <= 1'b1;
                        r_state     <= c_RSP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RSP: begin
                    if (rsp_ready) begin
                        r_state <= r_timed_out ? c_DRAIN : c_IDLE;
                    end
                end
                c_DRAIN: begin
                    if (r_write ? m_axi_bvalid : m_axi_rvalid) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_csr_axi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cpu_csr_axi_master
//  Purpose  : Self-checking bench for cpu_csr_axi_master with a responsive
//             AXI slave model and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_csr_axi_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [2:0]  err;
    } rsp_t;

    logic        s_aclk = 1'b0;
    logic        s_areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0]  cmd_id = 4'd0, cmd_wstrb = 4'd0;
    logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  rsp_id;
    logic [2:0]  rsp_err;
    logic [3:0]  m_axi_awid, m_axi_arid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_arvalid;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic [3:0]  m_axi_bid = 4'd0, m_axi_rid = 4'd0;
    logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic        m_axi_bvalid = 1'b0, m_axi_bready;
    logic [31:0] m_axi_rdata = 32'd0;
    logic        m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;

    always #5 s_aclk = ~s_aclk;

    cpu_csr_axi_master #(.TIMEOUT_CYCLES(8)) u_dut (
        .s_aclk(s_aclk), .s_areset(s_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Scoreboard and counters
    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   aw_wait_cnt = 0, aw_hi_cnt = 0, w_hi_cnt = 0, ar_hi_cnt = 0;
    int   b_hs_cnt = 0, rsp_wait_cnt = 0;

    // Slave behaviour knobs
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, rsp_delay = 0;
    bit         b_hold = 1'b0, r_hold = 1'b0, rlast_bad = 1'b0;
    logic [3:0] bid_xor = 4'd0, rid_xor = 4'd0;

    // Slave model state
    logic [31:0] slv_mem [0:63];
    int          aw_c = 0, w_c = 0, ar_c = 0;
    bit          got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0, b_fire = 1'b0, r_fire = 1'b0;
    logic [31:0] aw_a = 32'd0, ar_a = 32'd0, w_d = 32'd0;
    logic [3:0]  aw_i = 4'd0, ar_i = 4'd0, w_s = 4'd0;

    // Previous-cycle snapshots for stability checks
    bit          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_rsp = 1'b0;
    logic [35:0] p_aw_val = '0, p_w_val = '0, p_ar_val = '0;
    logic [40:0] p_rsp_val = '0;
    bit          chk_rdy_next = 1'b0, exp_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        return v;
    endfunction

    // rsp_ready: asserted after rsp_delay cycles of rsp_valid
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge s_aclk); #1;
            if (rsp_valid && !s_areset) begin
                if (c >= rsp_delay) rsp_ready = 1'b1;
                else begin rsp_ready = 1'b0; c++; end
            end else begin
                rsp_ready = 1'b0;
                c = 0;
            end
        end
    end

    // AXI slave model plus protocol/scoreboard monitor, all on the falling edge
    initial begin
        rsp_t e;
        forever begin
            @(negedge s_aclk);
            if (s_areset) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
                aw_c = 0; w_c = 0; ar_c = 0;
                p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0; chk_rdy_next = 0;
            end else begin
                if (chk_rdy_next) begin
                    check("cmd_ready_after_rsp", cmd_ready, exp_rdy);
                    chk_rdy_next = 0;
                end
                if (p_aw)  check("aw_stable",  {m_axi_awvalid, m_axi_awid, m_axi_awaddr}, {1'b1, p_aw_val});
                if (p_w)   check("w_stable",   {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {1'b1, p_w_val});
                if (p_ar)  check("ar_stable",  {m_axi_arvalid, m_axi_arid, m_axi_araddr}, {1'b1, p_ar_val});
                if (p_rsp) check("rsp_stable", {rsp_valid, rsp_rdata, rsp_resp, rsp_id, rsp_err},
                                 {1'b1, p_rsp_val});
                // B channel
                if (b_fire) begin
                    m_axi_bvalid = 0; b_fire = 0;
                end else if (!m_axi_bvalid && got_aw && got_w && !b_hold) begin
                    slv_mem[aw_a[7:2]] = merge(slv_mem[aw_a[7:2]], w_d, w_s);
                    m_axi_bvalid = 1; m_axi_bid = aw_i ^ bid_xor; m_axi_bresp = 2'b00;
                    got_aw = 0; got_w = 0;
                end
                // R channel
                if (r_fire) begin
                    m_axi_rvalid = 0; r_fire = 0;
                end else if (!m_axi_rvalid && got_ar && !r_hold) begin
                    m_axi_rvalid = 1; m_axi_rid = ar_i ^ rid_xor; m_axi_rresp = 2'b00;
                    m_axi_rdata = slv_mem[ar_a[7:2]]; m_axi_rlast = !rlast_bad;
                    got_ar = 0;
                end
                // AW channel
                if (m_axi_awready) m_axi_awready = 0;
                else if (m_axi_awvalid && !got_aw) begin
                    if (aw_c >= aw_delay) begin
                        m_axi_awready = 1; aw_c = 0; got_aw = 1;
                        aw_a = m_axi_awaddr; aw_i = m_axi_awid;
                    end else aw_c++;
                end
                // W channel
                if (m_axi_wready) m_axi_wready = 0;
                else if (m_axi_wvalid && !got_w) begin
                    if (w_c >= w_delay) begin
                        m_axi_wready = 1; w_c = 0; got_w = 1;
                        w_d = m_axi_wdata; w_s = m_axi_wstrb;
                    end else w_c++;
                end
                // AR channel
                if (m_axi_arready) m_axi_arready = 0;
                else if (m_axi_arvalid && !got_ar) begin
                    if (ar_c >= ar_delay) begin
                        m_axi_arready = 1; ar_c = 0; got_ar = 1;
                        ar_a = m_axi_araddr; ar_i = m_axi_arid;
                    end else ar_c++;
                end
                // Values presented to the coming rising edge
                if (m_axi_awvalid) begin
                    aw_hi_cnt++;
                    if (!m_axi_awready) aw_wait_cnt++;
                    else check("aw_attr", {m_axi_awlen, m_axi_awsize, m_axi_awburst}, {8'd0, 3'd2, 2'b01});
                end
                if (m_axi_wvalid) begin
                    w_hi_cnt++;
                    check("wlast", m_axi_wlast, 1'b1);
                end
                if (m_axi_arvalid) begin
                    ar_hi_cnt++;
                    if (m_axi_arready)
                        check("ar_attr", {m_axi_arlen, m_axi_arsize, m_axi_arburst}, {8'd0, 3'd2, 2'b01});
                end
                if (m_axi_bvalid && m_axi_bready) begin b_fire = 1; b_hs_cnt++; end
                if (m_axi_rvalid && m_axi_rready) r_fire = 1;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("rsp", {rsp_rdata, rsp_resp, rsp_id, rsp_err}, e);
                        exp_rdy = !e.err[2];
                        chk_rdy_next = 1;
                    end
                end
                if (rsp_valid && !rsp_ready) rsp_wait_cnt++;
                p_aw = m_axi_awvalid && !m_axi_awready;  p_aw_val = {m_axi_awid, m_axi_awaddr};
                p_w  = m_axi_wvalid && !m_axi_wready;    p_w_val  = {m_axi_wstrb, m_axi_wdata};
                p_ar = m_axi_arvalid && !m_axi_arready;  p_ar_val = {m_axi_arid, m_axi_araddr};
                p_rsp = rsp_valid && !rsp_ready;
                p_rsp_val = {rsp_rdata, rsp_resp, rsp_id, rsp_err};
            end
        end
    end

    task automatic tick();
        @(posedge s_aclk); #1;
    endtask

    task automatic send_cmd(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        bit acc;
        acc = 0;
        cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge s_aclk);
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accept", acc, 1'b1);
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp,
                            input logic [3:0] id, input logic [2:0] err);
        rsp_t e;
        e.rdata = rdata; e.resp = resp; e.id = id; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input bit need_idle);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge s_aclk);
            ok = (exp_q.size() == 0) && (cmd_ready || !need_idle);
        end
        check("wait_done", ok, 1'b1);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, w0, b0, r0, aw0, ar0;
        bit seen;
        for (int i = 0; i < 64; i++) slv_mem[i] = 32'hA5A5_0000 + i;

        // Reset state
        s_areset = 1'b1;
        repeat (3) tick();
        @(negedge s_aclk);
        check("reset_outputs", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                m_axi_bready, m_axi_rready, rsp_valid}, 7'b0);
        check("reset_rsp_fields", {rsp_rdata, rsp_resp, rsp_id, rsp_err}, 41'd0);
        tick();
        s_areset = 1'b0;
        @(negedge s_aclk);
        check("ready_after_reset", cmd_ready, 1'b1);
        tick();

        // Basic write then read-back
        push_exp(32'd0, 2'b00, 4'd1, 3'b000);
        send_cmd(1, 4'd1, 32'h14, 32'hDEADBEEF, 4'hF);
        wait_done(1);
        push_exp(32'hDEADBEEF, 2'b00, 4'd1, 3'b000);
        send_cmd(0, 4'd1, 32'h14, 32'd0, 4'h0);
        wait_done(1);

        // awready 3 cycles late, wready immediate
        aw_delay = 3;
        a0 = aw_wait_cnt; w0 = w_hi_cnt; b0 = b_hs_cnt;
        push_exp(32'd0, 2'b00, 4'd2, 3'b000);
        send_cmd(1, 4'd2, 32'h20, 32'h12345678, 4'hF);
        wait_done(1);
        check("aw_wait_cycles", aw_wait_cnt - a0, 3);
        check("w_valid_cycles", w_hi_cnt - w0, 1);
        check("b_handshakes", b_hs_cnt - b0, 1);
        aw_delay = 0;

        // Partial strobe write, read back with slow arready and slow wready
        w_delay = 2;
        push_exp(32'd0, 2'b00, 4'd3, 3'b000);
        send_cmd(1, 4'd3, 32'h20, 32'hAABBCCDD, 4'b0101);
        wait_done(1);
        w_delay = 0;
        ar_delay = 2;
        push_exp(32'h12BB56DD, 2'b00, 4'd4, 3'b000);
        send_cmd(0, 4'd4, 32'h20, 32'd0, 4'h0);
        wait_done(1);
        ar_delay = 0;

        // Response back-pressure for 5 cycles
        rsp_delay = 5;
        r0 = rsp_wait_cnt;
        push_exp(32'hDEADBEEF, 2'b00, 4'd5, 3'b000);
        send_cmd(0, 4'd5, 32'h14, 32'd0, 4'h0);
        wait_done(1);
        check("rsp_wait_cycles", rsp_wait_cnt - r0, 5);
        rsp_delay = 0;

        // Misaligned commands never reach the bus
        aw0 = aw_hi_cnt; ar0 = ar_hi_cnt;
        push_exp(32'd0, 2'b10, 4'd6, 3'b001);
        send_cmd(1, 4'd6, 32'h16, 32'h11111111, 4'hF);
        wait_done(1);
        push_exp(32'd0, 2'b10, 4'd7, 3'b001);
        send_cmd(0, 4'd7, 32'h03, 32'd0, 4'h0);
        wait_done(1);
        check("misaligned_no_axi", {aw_hi_cnt - aw0, ar_hi_cnt - ar0}, 64'd0);

        // ID mismatch on B, missing RLAST on R
        bid_xor = 4'h1;
        push_exp(32'd0, 2'b00, 4'd8, 3'b010);
        send_cmd(1, 4'd8, 32'h30, 32'h00000055, 4'hF);
        wait_done(1);
        bid_xor = 4'h0;
        rlast_bad = 1'b1;
        push_exp(32'h00000055, 2'b00, 4'd9, 3'b010);
        send_cmd(0, 4'd9, 32'h30, 32'd0, 4'h0);
        wait_done(1);
        rlast_bad = 1'b0;
        rid_xor = 4'h3;
        push_exp(32'hDEADBEEF, 2'b00, 4'd10, 3'b010);
        send_cmd(0, 4'd10, 32'h14, 32'd0, 4'h0);
        wait_done(1);
        rid_xor = 4'h0;

        // Write timeout, then late B drained without a second response
        b_hold = 1'b1;
        b0 = b_hs_cnt;
        push_exp(32'd0, 2'b11, 4'd11, 3'b100);
        send_cmd(1, 4'd11, 32'h40, 32'h00000001, 4'hF);
        wait_done(0);
        repeat (3) tick();
        @(negedge s_aclk);
        check("drain_hold", {cmd_ready, m_axi_bready, rsp_valid}, 3'b010);
        tick();
        b_hold = 1'b0;
        wait_done(1);
        check("drain_b_handshakes", b_hs_cnt - b0, 1);
        repeat (4) tick();

        // Reset pulse while waiting in RD_DATA
        r_hold = 1'b1;
        send_cmd(0, 4'd12, 32'h14, 32'd0, 4'h0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge s_aclk);
            seen = m_axi_rready;
        end
        check("reached_rd_data", seen, 1'b1);
        tick();
        s_areset = 1'b1;
        tick();
        s_areset = 1'b0;
        r_hold = 1'b0;
        @(negedge s_aclk);
        check("mid_reset_outputs", {m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready}, 4'b0001);
        check("mid_reset_rsp_fields", {rsp_rdata, rsp_resp, rsp_id, rsp_err}, 41'd0);
        tick();
        push_exp(32'h12BB56DD, 2'b00, 4'd13, 3'b000);
        send_cmd(0, 4'd13, 32'h20, 32'd0, 4'h0);
        wait_done(1);
        repeat (4) tick();
        check("queue_empty_at_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
